// File: rtl/vreg_read_sequencer_if.sv
// Command/status bundle between the vector control unit and one lane's
// VRF read sequencer: start command, consumer ready, counter strobes.
interface vreg_read_sequencer_if #(
   parameter int VL_W = 9
);
   logic            start_i;
   logic            abort_i;
   logic [VL_W-1:0] vl_i;
   logic [1:0]      sew_i;
   logic            up_down_i;
   logic            ready_i;
   logic            load_o;
   logic            rst_cnt_o;
   logic            en_o;
   logic [1:0]      sew_o;
   logic            up_down_o;
   logic            valid_o;
   logic            last_o;
   logic            busy_o;
   logic            done_o;
   logic            err_o;

   modport master (
      output start_i, abort_i, vl_i,
      output sew_i, up_down_i, ready_i,
      input  load_o, rst_cnt_o, en_o,
      input  sew_o, up_down_o,
      input  valid_o, last_o,
      input  busy_o, done_o, err_o
   );

   modport slave (
      input  start_i, abort_i, vl_i,
      input  sew_i, up_down_i, ready_i,
      output load_o, rst_cnt_o, en_o,
      output sew_o, up_down_o,
      output valid_o, last_o,
      output busy_o, done_o, err_o
   );
endinterface

// File: rtl/vreg_read_sequencer.sv
// Per-lane VRF read-port sequencer: loads the address counter, issues one
// read per element, delays valid/last by the VRF read latency, pulses done.
// Ports: clk_i, rst_i (async active-low), bus (slave side of the interface).
module vreg_read_sequencer #(
   parameter int MEM_DEPTH         = 512,
   parameter int VREG_LOC_PER_LANE = 8,
   parameter int READ_LATENCY      = 2,
   parameter int VL_W              = $clog2(VREG_LOC_PER_LANE*4*8)+1
) (
   input  logic clk_i,
   input  logic rst_i,
   vreg_read_sequencer_if.slave bus
);

   localparam bit CFG_OK = (READ_LATENCY >= 1) &&
                           (READ_LATENCY <= 4) &&
                           (VREG_LOC_PER_LANE <= MEM_DEPTH);

   if (!CFG_OK) begin : g_cfg_err
      $error("vreg_read_sequencer: bad parameters");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_e;

   state_e                  state_q, state_d;
   logic [VL_W-1:0]         rem_q, rem_d;
   logic [2:0]              drn_q, drn_d;
   logic [1:0]              sew_q, sew_d;
   logic                    dir_q, dir_d;
   logic                    err_q, err_d;
   logic [READ_LATENCY-1:0] vpipe_q, vpipe_d;
   logic [READ_LATENCY-1:0] lpipe_q, lpipe_d;

   logic en;
   logic last_issue;

   // Reads are issued straight from ready so the counter never
   // runs ahead of the consumer.
   assign en         = (state_q == S_RUN) & bus.ready_i;
   assign last_issue = en & (rem_q == VL_W'(1));

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      drn_d   = drn_q;
      sew_d   = sew_q;
      dir_d   = dir_q;
      err_d   = 1'b0;

      vpipe_d[0] = en;
      lpipe_d[0] = last_issue;
      for (int i = 1; i < READ_LATENCY; i++) begin
         vpipe_d[i] = vpipe_q[i-1];
         lpipe_d[i] = lpipe_q[i-1];
      end

      if (bus.abort_i) begin
         // Flush drops in-flight reads too, so nothing
         // from the killed command ever shows as valid.
         state_d = S_IDLE;
         rem_d   = '0;
         drn_d   = '0;
         vpipe_d = '0;
         lpipe_d = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (bus.start_i) begin
                  if (bus.sew_i == 2'b11) begin
                     err_d = 1'b1;
                  end else begin
                     sew_d = bus.sew_i;
                     dir_d = bus.up_down_i;
                     if (bus.vl_i == '0) begin
                        state_d = S_DONE;
                     end else begin
                        rem_d   = bus.vl_i;
                        state_d = S_LOAD;
                     end
                  end
               end
            end
            S_LOAD: begin
               state_d = S_RUN;
            end
            S_RUN: begin
               if (en) begin
                  rem_d = rem_q - VL_W'(1);
                  if (last_issue) begin
                     state_d = S_DRAIN;
                     drn_d   = 3'(READ_LATENCY-1);
                  end
               end
            end
            S_DRAIN: begin
               if (drn_q == '0) begin
                  state_d = S_DONE;
               end else begin
                  drn_d = drn_q - 3'd1;
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= S_IDLE;
         rem_q   <= '0;
         drn_q   <= '0;
         sew_q   <= '0;
         dir_q   <= 1'b0;
         err_q   <= 1'b0;
         vpipe_q <= '0;
         lpipe_q <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         drn_q   <= drn_d;
         sew_q   <= sew_d;
         dir_q   <= dir_d;
         err_q   <= err_d;
         vpipe_q <= vpipe_d;
         lpipe_q <= lpipe_d;
      end
   end

   assign bus.load_o    = (state_q == S_LOAD);
   assign bus.rst_cnt_o = (state_q == S_LOAD);
   assign bus.en_o      = en;
   assign bus.sew_o     = sew_q;
   assign bus.up_down_o = dir_q;
   assign bus.valid_o   = vpipe_q[READ_LATENCY-1];
   assign bus.last_o    = lpipe_q[READ_LATENCY-1] &
                          vpipe_q[READ_LATENCY-1];
   assign bus.busy_o    = (state_q != S_IDLE);
   assign bus.done_o    = (state_q == S_DONE);
   assign bus.err_o     = err_q;

endmodule

// File: tb/tb_vreg_read_sequencer.sv
// Scoreboard bench for vreg_read_sequencer: stimulus pushes expected
// read responses, a negedge monitor pops and checks them.
module tb_vreg_read_sequencer;
   localparam int RL   = 2;
   localparam int VL_W = 9;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   vreg_read_sequencer_if #(.VL_W(VL_W)) bus();

   vreg_read_sequencer #(
      .MEM_DEPTH(512),
      .VREG_LOC_PER_LANE(8),
      .READ_LATENCY(RL),
      .VL_W(VL_W)
   ) dut (
      .clk_i(clk),
      .rst_i(rst_n),
      .bus(bus)
   );

   int total = 0;
   int bad   = 0;

   bit exp_q[$];
   int en_t_q[$];
   int en_log[$];
   int t0    = 0;
   int rmode = 0;

   int en_cnt, valid_cnt, last_cnt, done_cnt;
   int err_cnt, load_cnt, busy_cnt;
   int load_cyc, first_valid_cyc, last_cyc;
   int done_cyc, err_cyc;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d required %0d", nm, act, exp);
      end
   endtask

   task automatic clear_logs();
      en_log.delete();
      en_cnt = 0; valid_cnt = 0; last_cnt = 0; done_cnt = 0;
      err_cnt = 0; load_cnt = 0; busy_cnt = 0;
      load_cyc = -1; first_valid_cyc = -1; last_cyc = -1;
      done_cyc = -1; err_cyc = -1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: a legal start with vl elements yields vl reads,
   // only the final one flagged last.
   task automatic issue(int vl, logic [1:0] sew, logic ud);
      clear_logs();
      t0 = cyc;
      bus.start_i   = 1'b1;
      bus.vl_i      = VL_W'(vl);
      bus.sew_i     = sew;
      bus.up_down_i = ud;
      if (sew != 2'b11)
         for (int i = 0; i < vl; i++) exp_q.push_back(i == vl - 1);
      step();
      bus.start_i = 1'b0;
   endtask

   task automatic wait_done(int budget);
      int n = 0;
      while (done_cnt == 0 && n < budget) begin
         step();
         n++;
      end
      if (done_cnt == 0) begin
         total++;
         bad++;
         $display("FAIL done_timeout: no done_o in %0d cycles", budget);
      end
   endtask

   initial begin
      bus.ready_i = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         case (rmode)
            0: bus.ready_i = 1'b1;
            1: bus.ready_i = 1'($urandom_range(0, 1));
            default: bus.ready_i = !((cyc - t0) >= 3 && (cyc - t0) <= 5);
         endcase
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.en_o) begin
            en_t_q.push_back(cyc);
            en_log.push_back(cyc - t0);
            en_cnt++;
         end
         if (bus.load_o) begin
            load_cnt++;
            load_cyc = cyc - t0;
            chk("rst_cnt_with_load", 32'(bus.rst_cnt_o), 1);
         end
         if (bus.last_o && !bus.valid_o) begin
            total++;
            bad++;
            $display("FAIL last_without_valid: last_o=1 valid_o=0");
         end
         if (bus.valid_o) begin
            if (exp_q.size() == 0 || en_t_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_valid: valid_o=1 at cycle %0d, required 0", cyc);
            end else begin
               chk("last_o", 32'(bus.last_o), 32'(exp_q.pop_front()));
               chk("read_latency", 32'(cyc - en_t_q.pop_front()), RL);
            end
            if (valid_cnt == 0) first_valid_cyc = cyc - t0;
            valid_cnt++;
            if (bus.last_o) begin
               last_cnt++;
               last_cyc = cyc - t0;
            end
         end
         if (bus.done_o) begin
            done_cnt++;
            done_cyc = cyc - t0;
         end
         if (bus.err_o) begin
            err_cnt++;
            err_cyc = cyc - t0;
         end
         if (bus.busy_o) busy_cnt++;
      end
   end

   initial begin
      logic [1:0] rs;
      logic       rd;
      int         rv;

      bus.start_i   = 1'b0;
      bus.abort_i   = 1'b0;
      bus.vl_i      = '0;
      bus.sew_i     = 2'b00;
      bus.up_down_i = 1'b0;
      clear_logs();
      repeat (3) step();
      chk("reset_outputs", 32'({bus.load_o, bus.rst_cnt_o, bus.en_o,
          bus.sew_o, bus.up_down_o, bus.valid_o, bus.last_o,
          bus.busy_o, bus.done_o, bus.err_o}), 0);
      rst_n = 1'b1;
      repeat (2) step();

      // basic
      rmode = 0;
      issue(5, 2'b10, 1'b1);
      chk("basic_sew_o", 32'(bus.sew_o), 2);
      chk("basic_dir_o", 32'(bus.up_down_o), 1);
      wait_done(40);
      chk("basic_load_cnt", load_cnt, 1);
      chk("basic_load_cyc", load_cyc, 1);
      chk("basic_en_cnt", en_cnt, 5);
      chk("basic_en_first", en_log[0], 2);
      chk("basic_en_last", en_log[4], 6);
      chk("basic_valid_first", first_valid_cyc, 4);
      chk("basic_last_cyc", last_cyc, 8);
      chk("basic_done_cyc", done_cyc, 9);
      chk("basic_last_cnt", last_cnt, 1);
      step();

      // stall
      rmode = 2;
      issue(3, 2'b10, 1'b0);
      wait_done(40);
      chk("stall_en_cnt", en_cnt, 3);
      chk("stall_en0", en_log[0], 2);
      chk("stall_en1", en_log[1], 6);
      chk("stall_en2", en_log[2], 7);
      chk("stall_valid_cnt", valid_cnt, 3);
      chk("stall_last_cyc", last_cyc, 9);
      rmode = 0;
      step();

      // illegal sew: no state change, sew_o holds
      issue(5, 2'b11, 1'b1);
      repeat (6) step();
      chk("illegal_err_cnt", err_cnt, 1);
      chk("illegal_err_cyc", err_cyc, 1);
      chk("illegal_busy", busy_cnt, 0);
      chk("illegal_load", load_cnt, 0);
      chk("illegal_sew_hold", 32'(bus.sew_o), 2);
      chk("illegal_dir_hold", 32'(bus.up_down_o), 0);

      // zero length
      issue(0, 2'b10, 1'b0);
      wait_done(10);
      chk("zero_done_cyc", done_cyc, 1);
      chk("zero_load", load_cnt, 0);
      chk("zero_en", en_cnt, 0);
      repeat (4) step();
      chk("zero_valid", valid_cnt, 0);

      // abort mid-run
      issue(8, 2'b01, 1'b1);
      while (cyc < t0 + 4) step();
      bus.abort_i = 1'b1;
      step();
      bus.abort_i = 1'b0;
      chk("abort_busy", 32'(bus.busy_o), 0);
      chk("abort_valid", 32'(bus.valid_o), 0);
      exp_q.delete();
      en_t_q.delete();
      step();
      chk("abort_no_done", done_cnt, 0);
      issue(3, 2'b00, 1'b0);
      wait_done(30);
      chk("post_abort_en", en_cnt, 3);
      chk("post_abort_valid", valid_cnt, 3);
      chk("post_abort_last", last_cnt, 1);
      step();

      // abort together with start in idle
      clear_logs();
      bus.start_i = 1'b1;
      bus.abort_i = 1'b1;
      bus.vl_i    = VL_W'(4);
      bus.sew_i   = 2'b10;
      step();
      bus.start_i = 1'b0;
      bus.abort_i = 1'b0;
      repeat (6) step();
      chk("abort_start_busy", busy_cnt, 0);
      chk("abort_start_en", en_cnt, 0);
      chk("abort_start_sew", 32'(bus.sew_o), 0);

      // start during run is ignored
      issue(6, 2'b10, 1'b1);
      while (cyc < t0 + 4) step();
      bus.start_i = 1'b1;
      bus.vl_i    = VL_W'(2);
      bus.sew_i   = 2'b01;
      step();
      bus.start_i = 1'b0;
      wait_done(40);
      chk("ign_en", en_cnt, 6);
      chk("ign_valid", valid_cnt, 6);
      chk("ign_load", load_cnt, 1);
      chk("ign_err", err_cnt, 0);
      chk("ign_sew", 32'(bus.sew_o), 2);
      step();

      // async reset mid-run
      issue(10, 2'b10, 1'b1);
      while (cyc < t0 + 4) step();
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_outputs", 32'({bus.load_o, bus.rst_cnt_o, bus.en_o,
          bus.sew_o, bus.up_down_o, bus.valid_o, bus.last_o,
          bus.busy_o, bus.done_o, bus.err_o}), 0);
      step();
      exp_q.delete();
      en_t_q.delete();
      rst_n = 1'b1;
      clear_logs();
      repeat (4) step();
      chk("rst_after_valid", valid_cnt, 0);
      chk("rst_after_busy", busy_cnt, 0);

      // random commands
      rmode = 1;
      for (int k = 0; k < 12; k++) begin
         rv = $urandom_range(1, 40);
         rs = 2'($urandom_range(0, 2));
         rd = 1'($urandom_range(0, 1));
         issue(rv, rs, rd);
         chk("rnd_sew_o", 32'(bus.sew_o), 32'(rs));
         chk("rnd_dir_o", 32'(bus.up_down_o), 32'(rd));
         wait_done(400);
         chk("rnd_en", en_cnt, rv);
         chk("rnd_valid", valid_cnt, rv);
         chk("rnd_last", last_cnt, 1);
         chk("rnd_q_empty", exp_q.size(), 0);
      end

      // max length
      issue(256, 2'b00, 1'b0);
      wait_done(3000);
      chk("max_en", en_cnt, 256);
      chk("max_valid", valid_cnt, 256);
      chk("max_last", last_cnt, 1);
      chk("max_done", done_cnt, 1);
      repeat (4) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
